// File: rtl/game_flow_ctrl.sv
// Game flow controller: welcome, play, death/respawn, level progression
// and end-of-game states, sequenced on video frame pulses.
module game_flow_ctrl #(
  parameter int unsigned INIT_LIVES   = 3,
  parameter int unsigned DIE_FRAMES   = 60,
  parameter int unsigned LEVEL_FRAMES = 90,
  parameter int unsigned NUM_LEVELS   = 4,
  parameter logic [3:0]  DIE_CODE     = 4'd6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       start_keyN,
  input  logic [3:0] player_state,
  input  logic       goal_reached,
  output logic       player_resetN,
  output logic [2:0] game_state,
  output logic [2:0] lives,
  output logic [2:0] level,
  output logic       game_over,
  output logic       win
);

  typedef enum logic [2:0] {
    S_WELCOME    = 3'd0,
    S_PLAY       = 3'd1,
    S_DYING      = 3'd2,
    S_RESPAWN    = 3'd3,
    S_LEVEL_DONE = 3'd4,
    S_GAME_OVER  = 3'd5,
    S_WIN        = 3'd6
  } state_e;

  localparam logic [2:0] INIT_L     = 3'(INIT_LIVES);
  localparam logic [2:0] LAST_LEVEL = 3'(NUM_LEVELS - 1);
  localparam logic [6:0] DIE_LAST   = 7'(DIE_FRAMES - 1);
  localparam logic [6:0] LVL_LAST   = 7'(LEVEL_FRAMES - 1);

  state_e     state_q, state_d;
  logic [2:0] lives_q, lives_d;
  logic [2:0] level_q, level_d;
  logic [6:0] frame_cnt_q, frame_cnt_d;
  logic       start_prev_q;
  logic       player_resetN_q, player_resetN_d;
  logic       game_over_q, game_over_d;
  logic       win_q, win_d;
  logic       start_press;

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    level_d     = level_q;
    frame_cnt_d = frame_cnt_q;
    start_press = !start_keyN && start_prev_q;
    case (state_q)
      S_WELCOME: begin
        if (start_press) state_d = S_PLAY;
      end
      S_PLAY: begin
        // Death takes priority over reaching the goal
        if (player_state == DIE_CODE) begin
          state_d     = S_DYING;
          lives_d     = (lives_q == 3'd0) ? 3'd0 : 3'(lives_q - 3'd1);
          frame_cnt_d = 7'd0;
        end else if (goal_reached) begin
          state_d     = S_LEVEL_DONE;
          frame_cnt_d = 7'd0;
        end
      end
      S_DYING: begin
        if (startOfFrame) begin
          if (frame_cnt_q == DIE_LAST)
            state_d = (lives_q == 3'd0) ? S_GAME_OVER : S_RESPAWN;
          else
            frame_cnt_d = 7'(frame_cnt_q + 7'd1);
        end
      end
      S_LEVEL_DONE: begin
        if (startOfFrame) begin
          if (frame_cnt_q == LVL_LAST) begin
            if (level_q == LAST_LEVEL) begin
              state_d = S_WIN;
            end else begin
              level_d = 3'(level_q + 3'd1);
              state_d = S_RESPAWN;
            end
          end else begin
            frame_cnt_d = 7'(frame_cnt_q + 7'd1);
          end
        end
      end
      S_RESPAWN: state_d = S_PLAY;
      S_GAME_OVER, S_WIN: begin
        if (start_press) begin
          lives_d = INIT_L;
          level_d = 3'd0;
          state_d = S_WELCOME;
        end
      end
      default: state_d = S_WELCOME;
    endcase
    player_resetN_d = (state_d == S_PLAY) || (state_d == S_DYING) ||
                      (state_d == S_LEVEL_DONE);
    game_over_d     = (state_d == S_GAME_OVER);
    win_d           = (state_d == S_WIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_WELCOME;
      lives_q         <= INIT_L;
      level_q         <= 3'd0;
      frame_cnt_q     <= 7'd0;
      start_prev_q    <= 1'b1;
      player_resetN_q <= 1'b0;
      game_over_q     <= 1'b0;
      win_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      lives_q         <= lives_d;
      level_q         <= level_d;
      frame_cnt_q     <= frame_cnt_d;
      start_prev_q    <= start_keyN;
      player_resetN_q <= player_resetN_d;
      game_over_q     <= game_over_d;
      win_q           <= win_d;
    end
  end

  assign game_state    = state_q;
  assign lives         = lives_q;
  assign level         = level_q;
  assign player_resetN = player_resetN_q;
  assign game_over     = game_over_q;
  assign win           = win_q;

endmodule
